// File: rtl/pong_game_ctrl_if.sv
// Game-controller bus: frame/collision events and button in, display-facing status out.
interface pong_game_ctrl_if;
    logic       btn_start;
    logic       refr_tick;
    logic       hit;
    logic       miss;
    logic       gra_still;
    logic [1:0] game_state;
    logic [7:0] score_bcd;
    logic [1:0] balls_left;
    logic       timer_busy;

    modport master (
        output btn_start, refr_tick, hit, miss,
        input  gra_still, game_state, score_bcd, balls_left, timer_busy
    );

    modport slave (
        input  btn_start, refr_tick, hit, miss,
        output gra_still, game_state, score_bcd, balls_left, timer_busy
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: new-game / play / new-ball / game-over flow,
// BCD score keeping, ball count and a frame-based hold timer.
module pong_game_ctrl #(
    parameter int NUM_BALLS    = 3,
    parameter int TIMER_FRAMES = 120
) (
    input  logic             clk,
    input  logic             reset,
    pong_game_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_t;

    localparam logic [1:0] BALLS_INIT = 2'(NUM_BALLS);
    localparam logic [7:0] TIMER_LOAD = 8'(TIMER_FRAMES);

    state_t     state, state_next;
    logic [7:0] score, score_next;
    logic [1:0] balls, balls_next;
    logic [7:0] timer, timer_next;
    logic       btn_q;
    logic       gra_still;
    logic       timer_busy;
    logic       start_edge;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = (v[7:4] == 4'd9) ? 8'h00 : {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    assign start_edge = bus.btn_start & ~btn_q;

    always_comb begin
        state_next = state;
        score_next = score;
        balls_next = balls;
        timer_next = (bus.refr_tick && timer != 8'd0) ? timer - 8'd1 : timer;
        case (state)
            NEWGAME: begin
                if (start_edge) begin
                    score_next = 8'h00;
                    balls_next = BALLS_INIT;
                    state_next = PLAY;
                end
            end
            PLAY: begin
                // a simultaneous hit is dropped when the ball is missed
                if (bus.miss) begin
                    balls_next = balls - 2'd1;
                    state_next = (balls == 2'd1) ? OVER : NEWBALL;
                    timer_next = TIMER_LOAD;
                end else if (bus.hit) begin
                    score_next = bcd_inc(score);
                end
            end
            NEWBALL: begin
                if (timer == 8'd0) state_next = PLAY;
            end
            OVER: begin
                if (timer == 8'd0) state_next = NEWGAME;
            end
            default: state_next = NEWGAME;
        endcase
    end

    // btn_q resets high so a button held through reset is not seen as a press
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= NEWGAME;
            score      <= 8'h00;
            balls      <= BALLS_INIT;
            timer      <= 8'd0;
            btn_q      <= 1'b1;
            gra_still  <= 1'b1;
            timer_busy <= 1'b0;
        end else begin
            state      <= state_next;
            score      <= score_next;
            balls      <= balls_next;
            timer      <= timer_next;
            btn_q      <= bus.btn_start;
            gra_still  <= (state_next != PLAY);
            timer_busy <= (timer_next != 8'd0);
        end
    end

    assign bus.game_state = state;
    assign bus.score_bcd  = score;
    assign bus.balls_left = balls;
    assign bus.gra_still  = gra_still;
    assign bus.timer_busy = timer_busy;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: directed game sequences plus random traffic
// against an integer-level game model.
module tb_pong_game_ctrl;

    localparam int NB = 3;
    localparam int TF = 120;

    logic clk = 1'b0;
    logic reset = 1'b0;
    pong_game_ctrl_if bus ();

    pong_game_ctrl #(.NUM_BALLS(NB), .TIMER_FRAMES(TF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       gra;
        logic [7:0] score;
        logic [1:0] balls;
        logic       busy;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // game model: phase 0 newgame, 1 play, 2 newball, 3 over; score kept as 0..99
    int m_phase, m_score, m_balls, m_timer;
    bit m_btn_prev;
    bit btn_lvl;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic model(input bit r, input bit b, input bit t, input bit h, input bit m);
        bit start;
        int tnext;
        if (!r) begin
            m_phase = 0; m_score = 0; m_balls = NB; m_timer = 0; m_btn_prev = 1;
            return;
        end
        start = b && !m_btn_prev;
        m_btn_prev = b;
        tnext = (t && m_timer > 0) ? m_timer - 1 : m_timer;
        if (m_phase == 0) begin
            if (start) begin
                m_score = 0; m_balls = NB; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (m) begin
                m_phase = (m_balls == 1) ? 3 : 2;
                m_balls = m_balls - 1;
                tnext = TF;
            end else if (h) begin
                m_score = (m_score + 1) % 100;
            end
        end else begin
            if (m_timer == 0) m_phase = (m_phase == 2) ? 1 : 0;
        end
        m_timer = tnext;
    endtask

    task automatic drive(input bit r, input bit b, input bit t, input bit h, input bit m);
        exp_t x;
        @(posedge clk);
        #1;
        reset = r;
        bus.btn_start = b;
        bus.refr_tick = t;
        bus.hit = h;
        bus.miss = m;
        model(r, b, t, h, m);
        x.cyc   = cyc + 1;
        x.st    = 2'(m_phase);
        x.gra   = (m_phase != 1);
        x.score = {4'(m_score / 10), 4'(m_score % 10)};
        x.balls = 2'(m_balls);
        x.busy  = (m_timer != 0);
        sb_q.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, btn_lvl, 0, 0, 0);
    endtask

    task automatic press_start();
        btn_lvl = 0; drive(1, 0, 0, 0, 0);
        btn_lvl = 1; drive(1, 1, 0, 0, 0);
        btn_lvl = 0; drive(1, 0, 0, 0, 0);
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1, btn_lvl, 0, 1, 0);
            if (i % 2 == 1) idle(1);
        end
    endtask

    task automatic ticks(input int n, input bit with_hits);
        for (int i = 0; i < n; i++) begin
            drive(1, btn_lvl, 1, with_hits && (i % 3 == 0), 0);
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic miss1();
        drive(1, btn_lvl, 0, 0, 1);
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            checks++;
            if ({bus.game_state, bus.gra_still, bus.score_bcd, bus.balls_left, bus.timer_busy} !==
                {e.st, e.gra, e.score, e.balls, e.busy}) begin
                errors++;
                $display("FAIL outputs@cyc%0d: got st=%b gra=%b score=%h balls=%0d busy=%b, expected st=%b gra=%b score=%h balls=%0d busy=%b",
                         cyc, bus.game_state, bus.gra_still, bus.score_bcd, bus.balls_left, bus.timer_busy,
                         e.st, e.gra, e.score, e.balls, e.busy);
            end
        end
    end

    initial begin
        bus.btn_start = 1'b1;
        bus.refr_tick = 1'b0;
        bus.hit = 1'b0;
        bus.miss = 1'b0;
        btn_lvl = 1;

        // reset with button held, then keep it held: no game start
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
        idle(5);
        press_start();
        hits(13);
        hits(87);
        hits(5);
        idle(2);
        // same-cycle hit and miss at score 05
        drive(1, btn_lvl, 0, 1, 1);
        hits(4);
        ticks(TF, 1);
        idle(3);
        miss1();
        ticks(TF, 0);
        idle(2);
        hits(7);
        miss1();
        ticks(TF, 1);
        idle(3);
        // start presses during OVER/NEWGAME settle
        press_start();
        press_start();
        hits(3);
        // reset mid-NEWBALL with timer at 50
        miss1();
        ticks(TF - 50, 0);
        drive(0, btn_lvl, 0, 0, 0);
        idle(3);
        press_start();
        hits(2);

        for (int i = 0; i < 4000; i++) begin
            bit r;
            r = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 7) == 0) btn_lvl = ~btn_lvl;
            drive(r, btn_lvl, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 15) == 0));
        end
        idle(2);

        for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(posedge clk);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-sequencing controller for the VGA Pong design. Sits between pixel_gen's collision/frame outputs and the graphics/text path. Runs the new-game / play / new-ball / game-over sequence, freezes the graphics between rallies, and keeps the BCD score and the remaining-ball count. Runs entirely in the 100 MHz system domain and is gated by pixel_gen's once-per-frame refresh tick.

Parameters:
NUM_BALLS, 3, balls per game; legal range 1..3.
TIMER_FRAMES, 120, frames held in NEWBALL and OVER (2 s at 60 Hz); legal range 1..255.

Ports:
clk  input  1  system clock (100 MHz); all logic on its rising edge.
reset  input  1  synchronous, active-low reset (0 = reset).
btn_start  input  1  debounced start button, level.
refr_tick  input  1  one-clk pulse per frame from pixel_gen.
hit  input  1  one-clk pulse: ball struck paddle.
miss  input  1  one-clk pulse: ball passed paddle.
gra_still  output  1  1 = hold ball at serve position and paddle frozen.
game_state  output  2  00 NEWGAME, 01 PLAY, 10 NEWBALL, 11 OVER.
score_bcd  output  8  [7:4] tens digit, [3:0] ones digit.
balls_left  output  2  balls remaining, binary.
timer_busy  output  1  1 while the frame timer is nonzero.

Behaviour:
- All outputs are registered. Reset (reset==0 at a clk edge) sets:
  - state NEWGAME, gra_still=1, score_bcd=8'h00, balls_left=NUM_BALLS;
  - timer=0, timer_busy=0, start-edge register=1.
  - The start-edge register resets to 1 so a button held through reset is not taken as a press.
- Reset asserted mid-operation in any state behaves the same way; no event in that cycle is counted.
- start_edge = btn_start & ~btn_start_q. btn_start_q is registered every clk.
- Frame timer: 8-bit down-counter.
  - Loaded with TIMER_FRAMES on entry to NEWBALL or OVER.
  - Decrements only on a refr_tick cycle, and only while nonzero.
  - timer_busy = (timer != 0).
- NEWGAME: gra_still=1; score and balls_left hold.
  - On start_edge: score_bcd <= 00, balls_left <= NUM_BALLS, go to PLAY.
- PLAY: gra_still=0.
  - hit: BCD increment of score_bcd. Ones digit 9 -> 0 with tens +1. 99 -> 00 (wrap, no flag).
  - miss:
    - balls_left decrements by 1.
    - If balls_left was 1, go to OVER; otherwise go to NEWBALL.
    - Timer loads TIMER_FRAMES.
  - hit and miss in the same cycle: miss wins and the hit is discarded (no score change).
- NEWBALL: gra_still=1; hit and miss are ignored.
  - The cycle the timer is 0 after at least one load, go to PLAY.
  - Time in NEWBALL is exactly TIMER_FRAMES refr_tick pulses, plus at most one clk.
- OVER: gra_still=1; score_bcd and balls_left (=0) hold for display; hit and miss are ignored.
  - When the timer reaches 0, go to NEWGAME. The score stays visible until the next start_edge.
- start_edge outside NEWGAME has no effect.
- Latency:
  - State, score and ball updates take effect on the clk edge that samples the qualifying input (visible the next cycle).
  - gra_still follows game_state in the same cycle (registered together).
- game_state encoding is fixed as listed and is consumed by the text overlay; there are no illegal states (all 4 codes are used).

Test Plan:
- Reset low 3 clks with btn_start=1, then release and keep btn_start=1 -> state 00, gra_still=1, score 00, balls 3; no PLAY entry until btn_start goes 0 then 1.
- start_edge, then 13 hit pulses -> state 01, score_bcd=8'h13; then 87 more hits -> 8'h00 (wrap at 99).
- In PLAY with balls=3, one miss -> balls=2, state 10, gra_still=1, timer_busy=1; after exactly 120 refr_ticks -> state 01, gra_still=0, score unchanged.
- Three misses with the NEWBALL waits -> third miss goes to state 11 with balls=0; 120 refr_ticks later -> state 00, score retained; start_edge -> score 00, balls 3.
- hit and miss in the same clk with score 8'h05, balls 3 -> score stays 05, balls=2, state 10; hit pulses in NEWBALL/OVER -> no score change.
- Reset asserted in NEWBALL with the timer at 50 -> next cycle state 00, timer_busy=0, score 00, balls 3.
